// File: rtl/rf_wb_scheduler.sv
// Register file writeback scheduler.
// Arbitrates ALU and LSU writeback requests onto one register file write port
// with a 1-bit round-robin pointer. A registered output stage adds one cycle
// of latency. A scoreboard tracks destination registers that have been issued
// but not yet committed, so that decode can detect hazards.
module rf_wb_scheduler (
   input  logic        clk_i,
   input  logic        rst_i,
   // Issue side: sets pending bits
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_rd_i,
   // ALU writeback requester
   input  logic        alu_valid_i,
   input  logic [4:0]  alu_rd_i,
   input  logic [31:0] alu_data_i,
   output logic        alu_ready_o,
   // LSU writeback requester
   input  logic        lsu_valid_i,
   input  logic [4:0]  lsu_rd_i,
   input  logic [31:0] lsu_data_i,
   output logic        lsu_ready_o,
   // Register file write port
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   // Hazard lookup from decode
   input  logic [4:0]  rs1_addr_i,
   input  logic [4:0]  rs2_addr_i,
   output logic        rs1_busy_o,
   output logic        rs2_busy_o
);

   localparam int unsigned DataWidth = 32;
   localparam int unsigned AddrWidth = 5;
   localparam int unsigned NumRegs   = 32;

   // Which requester wins when both are valid
   typedef enum logic {
      PtrAlu = 1'b0,
      PtrLsu = 1'b1
   } ptr_e;

   ptr_e                 ptr_q, ptr_d;
   logic                 alu_xfer, lsu_xfer, any_xfer;
   logic [AddrWidth-1:0] sel_rd;
   logic [DataWidth-1:0] sel_data;

   logic                 we_q, we_d;
   logic [AddrWidth-1:0] waddr_q, waddr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;

   logic [NumRegs-1:0]   pending_q, pending_d;

   // Ready depends only on the other requester's valid and the pointer, never
   // on the requester's own valid, so ready can be sampled before valid rises.
   always_comb begin
      alu_ready_o = 1'b1;
      lsu_ready_o = 1'b1;
      if (lsu_valid_i && (ptr_q == PtrLsu)) begin
         alu_ready_o = 1'b0;
      end
      if (alu_valid_i && (ptr_q == PtrAlu)) begin
         lsu_ready_o = 1'b0;
      end
   end

   // Handshake detection and winner selection; the two transfers are exclusive
   always_comb begin
      alu_xfer = alu_valid_i & alu_ready_o;
      lsu_xfer = lsu_valid_i & lsu_ready_o;
      any_xfer = alu_xfer | lsu_xfer;
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
      if (lsu_xfer) begin
         sel_rd   = lsu_rd_i;
         sel_data = lsu_data_i;
      end
   end

   // Pointer moves to the requester that was not served; holds when idle
   always_comb begin
      ptr_d = ptr_q;
      if (alu_xfer) begin
         ptr_d = PtrLsu;
      end else if (lsu_xfer) begin
         ptr_d = PtrAlu;
      end
   end

   // Round-robin pointer register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= PtrAlu;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   // Output stage next state: writes to x0 are accepted but never reach the
   // register file; address/data hold when nothing is written.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (any_xfer && (sel_rd != '0)) begin
         we_d    = 1'b1;
         waddr_d = sel_rd;
         wdata_d = sel_data;
      end
   end

   // Registered write port
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign rf_we_o    = we_q;
   assign rf_waddr_o = waddr_q;
   assign rf_wdata_o = wdata_q;

   // Scoreboard next state: clear on commit (when the register file actually
   // writes), then set on issue so a same-cycle set wins over the clear.
   always_comb begin
      pending_d = pending_q;
      if (we_q) begin
         pending_d[waddr_q] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != '0)) begin
         pending_d[issue_rd_i] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Scoreboard register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Hazard lookup; x0 is never busy
   always_comb begin
      rs1_busy_o = (rs1_addr_i != '0) && pending_q[rs1_addr_i];
      rs2_busy_o = (rs2_addr_i != '0) && pending_q[rs2_addr_i];
   end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 Parameter: none; data width SHALL be fixed at 32 bits and register addresses at 5 bits.
REQ-002 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 issue_valid_i  in  1  an instruction with destination issue_rd_i is issued this cycle.
REQ-005 issue_rd_i  in  5  destination register of the issued instruction.
REQ-006 alu_valid_i  in  1  ALU writeback request.
REQ-007 alu_rd_i  in  5  ALU destination register.
REQ-008 alu_data_i  in  32  ALU result.
REQ-009 alu_ready_o  out  1  ALU request accepted this cycle when alu_valid_i is also high.
REQ-010 lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_ready_o  in/in/in/out  1/5/32/1  LSU equivalents of REQ-006..009.
REQ-011 rf_we_o  out  1  register file write enable.
REQ-012 rf_waddr_o  out  5  register file write address.
REQ-013 rf_wdata_o  out  32  register file write data.
REQ-014 rs1_addr_i, rs2_addr_i  in  5  source registers being checked by decode.
REQ-015 rs1_busy_o, rs2_busy_o  out  1  source register has an uncommitted pending write.

Function
REQ-016 The single register file write port SHALL be shared between ALU and LSU; at most one request SHALL be accepted per cycle.
REQ-017 Transfer SHALL occur on a rising edge where valid and ready of the same requester are both high.
REQ-018 A requester SHALL hold valid, rd and data stable until transfer; the block SHALL NOT require valid to drop after transfer.
REQ-019 Only one requester valid: its ready SHALL be 1 combinationally in that cycle.
REQ-020 Both valid: grant SHALL go to the requester selected by a 1-bit round-robin pointer; the other ready SHALL be 0.
REQ-021 Pointer SHALL flip to the non-granted requester after every transfer and SHALL hold when no transfer occurs.
REQ-022 Neither valid: both ready SHALL be 1 (ready does not depend on own valid).
REQ-023 Output stage SHALL be registered: transfer at edge T drives rf_we_o=1 with rd and data during cycle T+1 (latency 1 cycle).
REQ-024 A transfer with rd=0 SHALL be accepted and SHALL update the pointer, but rf_we_o SHALL be 0 in the following cycle.
REQ-025 No transfer at edge T: rf_we_o SHALL be 0 in cycle T+1; rf_waddr_o/rf_wdata_o SHALL hold their previous values.
REQ-026 Scoreboard: a 32-bit pending mask; bit 0 SHALL be constant 0.
REQ-027 issue_valid_i with issue_rd_i!=0 SHALL set pending[issue_rd_i] at the edge.
REQ-028 pending[rf_waddr_o] SHALL clear at the edge where rf_we_o=1 (same edge the register file commits), not at the transfer edge.
REQ-029 Simultaneous set and clear of the same bit SHALL leave it set.
REQ-030 Issue to an already pending rd SHALL leave the bit set; one commit clears it (multiple outstanding writers to one rd are not tracked; issue logic prevents them).
REQ-031 rsN_busy_o SHALL equal pending[rsN_addr_i] combinationally; address 0 SHALL always return 0.

Reset
REQ-032 rst_i high SHALL immediately force rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, pending mask=0, pointer=ALU-first, independent of clk_i.
REQ-033 Reset during a pending write SHALL discard it; no write SHALL issue after reset deassertion until a new transfer.
REQ-034 During reset, ready outputs SHALL follow REQ-019..022 combinationally; transfers SHALL have no effect.

Verification
REQ-035 After reset, ALU and LSU both valid with rd=5/data=0xAAAA_0001 and rd=6/data=0xBBBB_0002 held -> ALU granted first, rf_we_o=1 rd=5 next cycle, then rd=6 one cycle later.
REQ-036 Both valid continuously for 6 cycles with valid re-asserted after each grant -> grants strictly alternate ALU/LSU, exactly one rf_we_o pulse per cycle.
REQ-037 issue rd=7 at cycle 0, ALU transfer rd=7 at cycle 3 -> rs1_busy_o(rs1=7)=1 through cycle 4, 0 from cycle 5; rf_we_o=1 in cycle 4.
REQ-038 LSU transfer rd=0 data=0xFFFF_FFFF -> lsu_ready_o=1, rf_we_o stays 0, pointer flips, rs1_busy_o(rs1=0)=0 always.
REQ-039 Commit of rd=9 at the same edge as issue of rd=9 -> pending[9] stays 1, rs2_busy_o(rs2=9)=1 afterwards.
REQ-040 Assert rst_i asynchronously mid-cycle while rf_we_o=1 -> rf_we_o and pending mask drop to 0 before the next clock edge; no write after release.
